// File: rtl/mem_responder.sv
// mem_responder: tagged main-memory responder with fixed-latency load returns
// and back-pressure by tag 0 when too many loads are in flight.
module mem_responder #(
   parameter int MEM_WORDS       = 4096,
   parameter int LATENCY         = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  proc2mem_command,
   input  logic [31:0] proc2mem_addr,
   input  logic [63:0] proc2mem_data,
   output logic [3:0]  mem2proc_response,
   output logic [63:0] mem2proc_data,
   output logic [3:0]  mem2proc_tag
);
   localparam int AW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [32:0] LIMIT = 33'(MEM_WORDS) * 33'd8;

   logic [63:0]        mem [MEM_WORDS];
   logic [LATENCY-1:0] v;
   logic [3:0]         t [LATENCY];
   logic [63:0]        d [LATENCY];
   logic [OW-1:0]      outstanding;
   logic [3:0]         next_tag;
   logic [AW-1:0]      idx;
   logic               in_range, is_load, is_store, emit, load_ok, accept;

   // a return leaving this cycle frees its slot for a same-cycle load
   always_comb begin
      idx               = proc2mem_addr[AW+2:3];
      in_range          = {1'b0, proc2mem_addr} < LIMIT;
      is_load           = proc2mem_command == 2'd1;
      is_store          = proc2mem_command == 2'd2;
      emit              = v[LATENCY-1];
      load_ok           = (outstanding - OW'(emit)) < OW'(MAX_OUTSTANDING);
      accept            = !reset && in_range && (is_store || (is_load && load_ok));
      mem2proc_response = accept ? next_tag : 4'd0;
      mem2proc_tag      = (!reset && emit) ? t[LATENCY-1] : 4'd0;
      mem2proc_data     = (!reset && emit) ? d[LATENCY-1] : 64'd0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         v           <= '0;
         outstanding <= '0;
         next_tag    <= 4'd1;
      end else begin
         v[0] <= accept && is_load;
         t[0] <= next_tag;
         d[0] <= mem[idx];
         for (int i = 1; i < LATENCY; i++) begin
            v[i] <= v[i-1];
            t[i] <= t[i-1];
            d[i] <= d[i-1];
         end
         outstanding <= outstanding + OW'(accept && is_load) - OW'(emit);
         if (accept) next_tag <= next_tag == 4'd15 ? 4'd1 : next_tag + 4'd1;
      end
   end

   always_ff @(posedge clock)
      if (accept && is_store) mem[idx] <= proc2mem_data;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed stimulus with a scoreboard of expected load returns.
module tb_mem_responder;
   localparam int L = 4;
   localparam int W = 4096;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  cmd = 2'd0;
   logic [31:0] addr = 32'd0;
   logic [63:0] wdata = 64'd0;
   logic [3:0]  response, tag;
   logic [63:0] rdata;

   typedef struct {
      logic [3:0]  tag;
      logic [63:0] data;
      int          due;
   } exp_t;

   exp_t        q[$];
   logic [63:0] model [int];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   mem_responder #(.MEM_WORDS(W), .LATENCY(L), .MAX_OUTSTANDING(2)) dut (
      .clock(clock),
      .reset(reset),
      .proc2mem_command(cmd),
      .proc2mem_addr(addr),
      .proc2mem_data(wdata),
      .mem2proc_response(response),
      .mem2proc_data(rdata),
      .mem2proc_tag(tag)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic req(input logic [1:0] c, input logic [31:0] a, input logic [63:0] dt,
                      input logic [3:0] exp);
      @(negedge clock);
      #1;
      cmd = c;
      addr = a;
      wdata = dt;
      #1;
      check("response", {60'd0, response}, {60'd0, exp});
      if (exp != 0 && c == 2'd1) q.push_back('{exp, model[int'(a[31:3])], cyc + L});
      if (exp != 0 && c == 2'd2) model[int'(a[31:3])] = dt;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) req(2'd0, 32'd0, 64'd0, 4'd0);
   endtask

   task automatic do_reset;
      @(negedge clock);
      #1;
      reset = 1'b1;
      cmd = 2'd1;
      addr = 32'h100;
      #1;
      check("reset_response", {60'd0, response}, 64'd0);
      q.delete();
      @(negedge clock);
      #1;
      reset = 1'b0;
      cmd = 2'd0;
   endtask

   always @(negedge clock) begin
      #3;
      if (tag != 4'd0) begin
         if (q.size() == 0) check("spurious_tag", {60'd0, tag}, 64'd0);
         else begin
            exp_t e;
            e = q.pop_front();
            check("ret_tag", {60'd0, tag}, {60'd0, e.tag});
            check("ret_data", rdata, e.data);
            check("ret_cycle", 64'(cyc), 64'(e.due));
         end
      end else begin
         check("idle_data", rdata, 64'd0);
         if (q.size() > 0 && q[0].due <= cyc) begin
            check("missing_tag", {60'd0, tag}, {60'd0, q[0].tag});
            void'(q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      do_reset();
      // store then load in the next cycle
      req(2'd2, 32'h100, 64'hDEADBEEF_CAFEF00D, 4'd1);
      req(2'd1, 32'h100, 64'd0, 4'd2);
      idle(6);
      // back-pressure and same-cycle slot reuse
      do_reset();
      req(2'd1, 32'h100, 64'd0, 4'd1);
      req(2'd1, 32'h100, 64'd0, 4'd2);
      req(2'd1, 32'h100, 64'd0, 4'd0);
      req(2'd1, 32'h100, 64'd0, 4'd0);
      req(2'd1, 32'h100, 64'd0, 4'd3);
      idle(6);
      // tag wrap on stores
      do_reset();
      for (int i = 0; i < 16; i++)
         req(2'd2, 32'h200 + 32'(8 * i), 64'h0101_0101_0101_0101 * 64'(i + 1), 4'((i % 15) + 1));
      // rejects and address boundary
      req(2'd2, 32'h7FF8, 64'h0123_4567_89AB_CDEF, 4'd2);
      req(2'd1, 32'(W * 8), 64'd0, 4'd0);
      req(2'd2, 32'(W * 8), 64'h5555, 4'd0);
      req(2'd3, 32'h100, 64'd0, 4'd0);
      req(2'd1, 32'hFFFF_FFF8, 64'd0, 4'd0);
      req(2'd1, 32'h7FF8, 64'd0, 4'd3);
      idle(6);
      // reset mid-flight drops in-flight loads
      do_reset();
      req(2'd1, 32'h100, 64'd0, 4'd1);
      req(2'd1, 32'h200, 64'd0, 4'd2);
      do_reset();
      req(2'd1, 32'h100, 64'd0, 4'd1);
      idle(8);
      // load data is snapshotted at acceptance
      req(2'd2, 32'h40, 64'hAAAA_0000_AAAA_0000, 4'd2);
      req(2'd1, 32'h40, 64'd0, 4'd3);
      req(2'd2, 32'h40, 64'hBBBB_1111_BBBB_1111, 4'd4);
      req(2'd1, 32'h40, 64'd0, 4'd5);
      idle(6);
      check("scoreboard_empty", 64'(q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
